// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the CPU memory bus: widths, FSM encoding, owner codes,
// and the IF/LS pick rule.
package mem_bus_arbiter_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 16;

    // Arbiter FSM encoding
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_BUSY = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    // Bus owner codes, visible on the owner output
    localparam logic [1:0] OWNER_NONE = 2'b00;
    localparam logic [1:0] OWNER_IF   = 2'b01;
    localparam logic [1:0] OWNER_LS   = 2'b10;

    // LS has priority unless IF is waiting and LS has used up its streak
    function automatic logic ls_wins(input logic if_req, input logic ls_req,
                                     input logic streak_full);
        return ls_req && (!if_req || !streak_full);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the requesters (IF, LS), the arbiter and the memory model.
// master = arbiter side, slave = requesters plus memory.
interface mem_bus_arbiter_if;
    import mem_bus_arbiter_pkg::*;

    // Fetch requester
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_done;
    logic [DATA_W-1:0] if_rdata;

    // Load/store requester
    logic              ls_req;
    logic              ls_we;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic              ls_gnt;
    logic              ls_done;
    logic [DATA_W-1:0] ls_rdata;

    // Memory side
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    // Status
    logic              bus_err;
    logic [1:0]        owner;

    modport master (
        input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_ack, mem_rdata,
        output if_gnt, if_done, if_rdata, ls_gnt, ls_done, ls_rdata,
               mem_req, mem_we, mem_addr, mem_wdata, bus_err, owner
    );

    modport slave (
        output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_ack, mem_rdata,
        input  if_gnt, if_done, if_rdata, ls_gnt, ls_done, ls_rdata,
               mem_req, mem_we, mem_addr, mem_wdata, bus_err, owner
    );

endinterface

// File: rtl/mem_bus_arbiter_wait_timer.sv
// Wait-state timer: loadable up-counter with clear; hit flags that the count
// has reached TIMEOUT. Saturates at TIMEOUT.
module mem_bus_arbiter_wait_timer #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             inc,
    output logic             hit
);

    logic [CNT_W-1:0] cnt_q;

    // Clear beats load, load beats increment
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (inc && !hit) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign hit = (cnt_q == CNT_W'(TIMEOUT));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single memory port between instruction fetch (IF) and
// load/store (LS): LS-first priority with an IF anti-starvation streak limit,
// req/ack handshake with memory and a wait-state timeout.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned MAX_STREAK = 4,
    parameter int unsigned TIMEOUT    = 15
) (
    input logic               clk,
    input logic               rst,
    mem_bus_arbiter_if.master bus
);

    localparam int unsigned SW    = (MAX_STREAK < 1) ? 1 : $clog2(MAX_STREAK + 1);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [1:0]        state_q,     state_d;
    logic [1:0]        owner_q,     owner_d;
    logic [SW-1:0]     streak_q,    streak_d;
    logic              if_gnt_q,    if_gnt_d;
    logic              ls_gnt_q,    ls_gnt_d;
    logic              if_done_q,   if_done_d;
    logic              ls_done_q,   ls_done_d;
    logic              bus_err_q,   bus_err_d;
    logic              mem_req_q,   mem_req_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0] ls_rdata_q,  ls_rdata_d;

    logic timer_clr, timer_load, timer_inc, timeout_hit;
    logic streak_full, pick_ls, pick_if, finish, timed_out;

    // The timer is loaded with 1 on grant, so its count equals the BUSY cycle index
    mem_bus_arbiter_wait_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (timer_clr),
        .load     (timer_load),
        .load_val (CNT_W'(1)),
        .inc      (timer_inc),
        .hit      (timeout_hit)
    );

    assign streak_full = (streak_q == SW'(MAX_STREAK));
    assign pick_ls     = ls_wins(bus.if_req, bus.ls_req, streak_full);
    assign pick_if     = bus.if_req && !pick_ls;
    // Ack takes precedence over a timeout hit in the same cycle
    assign finish      = bus.mem_ack || timeout_hit;
    assign timed_out   = !bus.mem_ack;

    // Next-state: FSM, pick, streak, transfer latching and result capture
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        streak_d    = streak_q;
        if_gnt_d    = 1'b0;
        ls_gnt_d    = 1'b0;
        if_done_d   = 1'b0;
        ls_done_d   = 1'b0;
        bus_err_d   = 1'b0;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        ls_rdata_d  = ls_rdata_q;
        timer_clr   = 1'b0;
        timer_load  = 1'b0;
        timer_inc   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                owner_d   = OWNER_NONE;
                timer_clr = 1'b1;
                if (pick_ls) begin
                    state_d     = ST_BUSY;
                    owner_d     = OWNER_LS;
                    ls_gnt_d    = 1'b1;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.ls_we;
                    mem_addr_d  = bus.ls_addr;
                    mem_wdata_d = bus.ls_wdata;
                    timer_clr   = 1'b0;
                    timer_load  = 1'b1;
                    if (bus.if_req) begin
                        streak_d = streak_full ? streak_q : streak_q + SW'(1);
                    end else begin
                        streak_d = '0;
                    end
                end else if (pick_if) begin
                    state_d     = ST_BUSY;
                    owner_d     = OWNER_IF;
                    if_gnt_d    = 1'b1;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.if_addr;
                    mem_wdata_d = '0;
                    timer_clr   = 1'b0;
                    timer_load  = 1'b1;
                    streak_d    = '0;
                end
            end
            ST_BUSY: begin
                timer_inc = 1'b1;
                if (finish) begin
                    state_d   = ST_DONE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    bus_err_d = timed_out;
                    if (owner_q == OWNER_IF) begin
                        if_done_d  = 1'b1;
                        if_rdata_d = timed_out ? '0 : bus.mem_rdata;
                    end else begin
                        ls_done_d = 1'b1;
                        if (timed_out) begin
                            ls_rdata_d = '0;
                        end else if (!mem_we_q) begin
                            ls_rdata_d = bus.mem_rdata;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d   = ST_IDLE;
                owner_d   = OWNER_NONE;
                timer_clr = 1'b1;
            end
            default: begin
                state_d   = ST_IDLE;
                owner_d   = OWNER_NONE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
                timer_clr = 1'b1;
            end
        endcase
    end

    // State and registered outputs; reset drops mem_req on the next edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWNER_NONE;
            streak_q    <= '0;
            if_gnt_q    <= 1'b0;
            ls_gnt_q    <= 1'b0;
            if_done_q   <= 1'b0;
            ls_done_q   <= 1'b0;
            bus_err_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            streak_q    <= streak_d;
            if_gnt_q    <= if_gnt_d;
            ls_gnt_q    <= ls_gnt_d;
            if_done_q   <= if_done_d;
            ls_done_q   <= ls_done_d;
            bus_err_q   <= bus_err_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            ls_rdata_q  <= ls_rdata_d;
        end
    end

    assign bus.if_gnt    = if_gnt_q;
    assign bus.ls_gnt    = ls_gnt_q;
    assign bus.if_done   = if_done_q;
    assign bus.ls_done   = ls_done_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.ls_rdata  = ls_rdata_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.bus_err   = bus_err_q;
    assign bus.owner     = owner_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level reference model.
module tb_mem_bus_arbiter;

    localparam int MAX_STREAK = 4;
    localparam int TIMEOUT    = 15;
    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_IF   = 2'b01;
    localparam logic [1:0] OWN_LS   = 2'b10;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    // Reference model state
    int          m_streak;
    logic [15:0] m_if_rd;
    logic [15:0] m_ls_rd;

    mem_bus_arbiter_if bus ();

    mem_bus_arbiter #(
        .MAX_STREAK (MAX_STREAK),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".if_gnt"},    16'(bus.if_gnt),    16'h0);
        chk({tag, ".if_done"},   16'(bus.if_done),   16'h0);
        chk({tag, ".if_rdata"},  bus.if_rdata,       16'h0);
        chk({tag, ".ls_gnt"},    16'(bus.ls_gnt),    16'h0);
        chk({tag, ".ls_done"},   16'(bus.ls_done),   16'h0);
        chk({tag, ".ls_rdata"},  bus.ls_rdata,       16'h0);
        chk({tag, ".mem_req"},   16'(bus.mem_req),   16'h0);
        chk({tag, ".mem_we"},    16'(bus.mem_we),    16'h0);
        chk({tag, ".mem_addr"},  bus.mem_addr,       16'h0);
        chk({tag, ".mem_wdata"}, bus.mem_wdata,      16'h0);
        chk({tag, ".bus_err"},   16'(bus.bus_err),   16'h0);
        chk({tag, ".owner"},     16'(bus.owner),     16'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_streak = 0;
        m_if_rd  = '0;
        m_ls_rd  = '0;
    endtask

    // One full transfer starting in an IDLE cycle with the requests already driven.
    // ack_cyc is the BUSY cycle (1-based) in which mem_ack is raised; beyond
    // TIMEOUT means no ack at all.
    task automatic xfer(input string tag, input int ack_cyc, input logic [15:0] rd,
                        output logic [1:0] got);
        logic [1:0]  exp_own;
        logic        exp_we;
        logic [15:0] exp_addr;
        logic [15:0] exp_wdata;
        logic        tmo;
        int          end_cyc;

        // Reference pick and streak bookkeeping
        if (bus.ls_req && (!bus.if_req || m_streak < MAX_STREAK)) begin
            exp_own   = OWN_LS;
            exp_we    = bus.ls_we;
            exp_addr  = bus.ls_addr;
            exp_wdata = bus.ls_wdata;
            m_streak  = bus.if_req ? ((m_streak < MAX_STREAK) ? m_streak + 1 : m_streak) : 0;
        end else begin
            exp_own   = OWN_IF;
            exp_we    = 1'b0;
            exp_addr  = bus.if_addr;
            exp_wdata = '0;
            m_streak  = 0;
        end

        step();
        got = bus.owner;
        chk({tag, ".owner"},   16'(bus.owner),   16'(exp_own));
        chk({tag, ".if_gnt"},  16'(bus.if_gnt),  16'(exp_own == OWN_IF));
        chk({tag, ".ls_gnt"},  16'(bus.ls_gnt),  16'(exp_own == OWN_LS));
        chk({tag, ".mem_req"}, 16'(bus.mem_req), 16'h1);
        chk({tag, ".mem_addr"}, bus.mem_addr,    exp_addr);
        chk({tag, ".mem_we"},  16'(bus.mem_we),  16'(exp_we));
        if (exp_own == OWN_LS && exp_we) chk({tag, ".mem_wdata"}, bus.mem_wdata, exp_wdata);
        if (exp_own == OWN_LS) bus.ls_req = 1'b0;
        else                   bus.if_req = 1'b0;

        tmo     = (ack_cyc > TIMEOUT);
        end_cyc = tmo ? TIMEOUT : ack_cyc;
        for (int k = 1; k <= end_cyc; k++) begin
            if (k == ack_cyc) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = rd;
            end else begin
                bus.mem_rdata = 16'($urandom);
            end
            step();
            bus.mem_ack = 1'b0;
            if (k < end_cyc) begin
                chk({tag, ".busy_req"},  16'(bus.mem_req), 16'h1);
                chk({tag, ".busy_done"}, 16'(bus.if_done | bus.ls_done), 16'h0);
            end
        end

        if (tmo) begin
            if (exp_own == OWN_IF) m_if_rd = '0;
            else                   m_ls_rd = '0;
        end else if (exp_own == OWN_IF) begin
            m_if_rd = rd;
        end else if (!exp_we) begin
            m_ls_rd = rd;
        end
        chk({tag, ".if_done"},   16'(bus.if_done), 16'(exp_own == OWN_IF));
        chk({tag, ".ls_done"},   16'(bus.ls_done), 16'(exp_own == OWN_LS));
        chk({tag, ".bus_err"},   16'(bus.bus_err), 16'(tmo));
        chk({tag, ".done_req"},  16'(bus.mem_req), 16'h0);
        chk({tag, ".if_rdata"},  bus.if_rdata,     m_if_rd);
        chk({tag, ".ls_rdata"},  bus.ls_rdata,     m_ls_rd);

        step();
        chk({tag, ".idle_owner"}, 16'(bus.owner), 16'(OWN_NONE));
        chk({tag, ".idle_pulse"},
            16'(bus.if_done | bus.ls_done | bus.bus_err | bus.if_gnt | bus.ls_gnt), 16'h0);
        chk({tag, ".idle_req"},   16'(bus.mem_req), 16'h0);
    endtask

    logic [1:0] got;
    logic [1:0] pat [6];

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b0;
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.ls_req    = 1'b0;
        bus.ls_we     = 1'b0;
        bus.ls_addr   = '0;
        bus.ls_wdata  = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;

        // Reset state
        do_reset();
        chk_all_zero("reset");

        // Single fetch, ack in the 3rd BUSY cycle
        bus.if_req  = 1'b1;
        bus.if_addr = 16'h0010;
        xfer("fetch", 3, 16'hA5A5, got);
        chk("fetch.rdata", bus.if_rdata, 16'hA5A5);

        // Collision: LS store first, then the waiting IF
        bus.if_req   = 1'b1;
        bus.if_addr  = 16'h0020;
        bus.ls_req   = 1'b1;
        bus.ls_we    = 1'b1;
        bus.ls_addr  = 16'h0200;
        bus.ls_wdata = 16'h1234;
        xfer("coll_ls", 1, 16'hDEAD, got);
        chk("coll.first", 16'(got), 16'(OWN_LS));
        xfer("coll_if", 2, 16'h0F0F, got);
        chk("coll.second", 16'(got), 16'(OWN_IF));

        // Starvation: LS always pending, IF waiting
        do_reset();
        pat[0] = OWN_LS; pat[1] = OWN_LS; pat[2] = OWN_LS;
        pat[3] = OWN_LS; pat[4] = OWN_IF; pat[5] = OWN_LS;
        bus.if_req  = 1'b1;
        bus.if_addr = 16'h0100;
        for (int i = 0; i < 6; i++) begin
            bus.ls_req  = 1'b1;
            bus.ls_we   = 1'b0;
            bus.ls_addr = 16'h0300 + 16'(i);
            xfer("starve", 1, 16'h4000 + 16'(i), got);
            chk($sformatf("starve.grant%0d", i), 16'(got), 16'(pat[i]));
        end

        // Timeout with no ack, then a normal fetch
        bus.if_req  = 1'b1;
        bus.if_addr = 16'h0044;
        xfer("timeout", TIMEOUT + 1, 16'h7777, got);
        chk("timeout.rdata", bus.if_rdata, 16'h0000);
        bus.if_req  = 1'b1;
        bus.if_addr = 16'h0046;
        xfer("after_to", 2, 16'h3C3C, got);

        // Ack in the very cycle the count reaches TIMEOUT
        bus.ls_req  = 1'b1;
        bus.ls_we   = 1'b0;
        bus.ls_addr = 16'h0500;
        xfer("ack_edge", TIMEOUT, 16'hBEEF, got);
        chk("ack_edge.rdata", bus.ls_rdata, 16'hBEEF);

        // Reset in the middle of BUSY; a late ack must not complete anything
        bus.if_req  = 1'b1;
        bus.if_addr = 16'h0600;
        step();
        chk("rstmid.gnt", 16'(bus.if_gnt), 16'h1);
        bus.if_req = 1'b0;
        step();
        step();
        do_reset();
        chk_all_zero("rstmid");
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'h9999;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rstmid.late_done", 16'(bus.if_done | bus.ls_done), 16'h0);
            chk("rstmid.late_req",  16'(bus.mem_req), 16'h0);
            chk("rstmid.late_rd",   bus.if_rdata, 16'h0);
        end
        bus.mem_ack = 1'b0;

        // Randomized traffic against the reference model
        for (int n = 0; n < 60; n++) begin
            int ack_cyc;
            if (!bus.if_req && ($urandom_range(0, 1) == 1)) begin
                bus.if_req  = 1'b1;
                bus.if_addr = 16'($urandom);
            end
            if (!bus.ls_req && ($urandom_range(0, 1) == 1)) begin
                bus.ls_req   = 1'b1;
                bus.ls_we    = 1'($urandom_range(0, 1));
                bus.ls_addr  = 16'($urandom);
                bus.ls_wdata = 16'($urandom);
            end
            if (!bus.if_req && !bus.ls_req) begin
                bus.if_req  = 1'b1;
                bus.if_addr = 16'($urandom);
            end
            ack_cyc = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TIMEOUT - 1, TIMEOUT + 2))
                                                  : int'($urandom_range(1, 4));
            xfer("rand", ack_cyc, 16'($urandom), got);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
